// File: rtl/drum_mac_acc.sv
// drum_mac_acc: block accumulator for DRUMk_M_N_s products; define DRUM_MAC_ACC_SAT_EN for saturating adds
module drum_mac_acc #(
    parameter int N     = 16,
    parameter int M     = 16,
    parameter int LEN   = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N+M-1:0]   in_prod,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [CW-1:0]    cnt;
    logic             sticky;
    logic             clamp;
    logic             in_hs;
    logic             last;

    assign prod_ext  = ACC_W'($signed(in_prod));
    assign out_valid = state == FULL;
    assign in_ready  = clr | (state == EMPTY) | out_ready | (cnt != LAST);
    assign in_hs     = in_valid & in_ready & ~clr;
    assign last      = in_hs & (cnt == LAST);

`ifdef DRUM_MAC_ACC_SAT_EN
    logic [ACC_W:0] wide;
    assign wide  = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    assign clamp = wide[ACC_W] ^ wide[ACC_W-1];
    assign sum   = clamp ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
`else
    assign clamp = 1'b0;
    assign sum   = acc + prod_ext;
`endif

    // running accumulator and product count; clr and block completion both restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (clr || last) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (in_hs) begin
            acc    <= sum;
            cnt    <= cnt + 1'b1;
            sticky <= sticky | clamp;
        end
    end

    // output holding register: load on block completion, drain on consumer handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (last) begin
            state   <= FULL;
            out_sum <= sum;
            out_ovf <= sticky | clamp;
        end else if (state == FULL && out_ready) begin
            state   <= EMPTY;
        end
    end
endmodule

// File: tb/tb_drum_mac_acc.sv
// tb_drum_mac_acc: directed and randomized check of drum_mac_acc against a behavioural model
module tb_drum_mac_acc;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        in_valid = 0;
    logic        clr = 0;
    logic        out_ready = 0;
    logic [31:0] in_prod = 0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ovf;
    logic [31:0] out_sum;

    int checks = 0;
    int errors = 0;

    longint      acc_m;
    longint      s_m;
    int          cnt_m;
    bit          full_m;
    bit          ovf_m;
    bit          sticky_m;
    bit          hs_m;
    bit          take_m;
    bit          cl_m;
    logic [31:0] sum_m;

    drum_mac_acc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready();
        return clr || !full_m || out_ready || cnt_m != 7;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit v, logic [31:0] p, bit c, bit r);
        in_valid = v;
        in_prod = p;
        clr = c;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    // reference model: block sums as plain integer arithmetic, evaluated just after each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_m = 0; cnt_m = 0; full_m = 0; ovf_m = 0; sticky_m = 0; sum_m = 0;
        end else begin
            #1;
            hs_m = in_valid && exp_ready() && !clr;
            take_m = full_m && out_ready;
            if (clr) begin
                acc_m = 0; cnt_m = 0; sticky_m = 0;
            end else if (hs_m) begin
                s_m = acc_m + longint'($signed(in_prod));
                cl_m = 0;
`ifdef DRUM_MAC_ACC_SAT_EN
                if (s_m > MAXV) begin s_m = MAXV; cl_m = 1; end
                else if (s_m < MINV) begin s_m = MINV; cl_m = 1; end
`else
                s_m = longint'(int'(s_m));
`endif
                if (cnt_m == 7) begin
                    sum_m = s_m[31:0]; ovf_m = sticky_m | cl_m; full_m = 1;
                    acc_m = 0; cnt_m = 0; sticky_m = 0; take_m = 0;
                end else begin
                    acc_m = s_m; cnt_m++; sticky_m |= cl_m;
                end
            end
            if (take_m) full_m = 0;
        end
    end

    // every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_out_valid", out_valid, full_m);
            chk("cyc_in_ready", in_ready, exp_ready());
            if (full_m) begin
                chk("cyc_out_sum", out_sum, sum_m);
                chk("cyc_out_ovf", out_ovf, ovf_m);
            end
        end
    end

    initial begin
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1;
        // eight products of 1000
        for (int i = 0; i < 7; i++) step(1, 1000, 0, 1);
        chk("s1_early", out_valid, 0);
        step(1, 1000, 0, 1);
        chk("s1_valid", out_valid, 1);
        chk("s1_sum", out_sum, 8000);
        chk("s1_model", sum_m, 8000);
        step(0, 0, 0, 1);
        chk("s1_pulse", out_valid, 0);
        // alternating +300 / -500
        for (int i = 0; i < 8; i++) step(1, (i % 2) ? 32'hFFFFFE0C : 32'd300, 0, 1);
        chk("s2_sum", out_sum, 32'hFFFFFCE0);
        chk("s2_model", sum_m, 32'hFFFFFCE0);
        step(0, 0, 0, 1);
        // back-pressure across two blocks of ones
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        chk("s3_valid", out_valid, 1);
        chk("s3_sum1", out_sum, 8);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        chk("s3_hold", out_sum, 8);
        #1;
        chk("s3_stall", in_ready, 0);
        #1;
        step(1, 1, 0, 0);
        chk("s3_stall2", in_ready, 0);
        chk("s3_hold2", out_sum, 8);
        step(1, 1, 0, 1);
        chk("s3_reload_valid", out_valid, 1);
        chk("s3_sum2", out_sum, 8);
        step(0, 0, 0, 1);
        chk("s3_drain", out_valid, 0);
        // clear discards a partial block and the product presented with it
        for (int i = 0; i < 3; i++) step(1, 5, 0, 1);
        step(1, 99, 1, 1);
        for (int i = 0; i < 8; i++) step(1, 2, 0, 1);
        chk("s4_sum", out_sum, 16);
        chk("s4_model", sum_m, 16);
        step(0, 0, 0, 1);
        // reset mid-block with a held output
        for (int i = 0; i < 8; i++) step(1, 4, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 7, 0, 0);
        chk("s5_pre_valid", out_valid, 1);
        rst_n = 0;
        #1;
        chk("s5_valid", out_valid, 0);
        chk("s5_sum", out_sum, 0);
        chk("s5_ovf", out_ovf, 0);
        chk("s5_ready", in_ready, 1);
        #1;
        step(0, 0, 0, 0);
        rst_n = 1;
        for (int i = 0; i < 8; i++) step(1, 3, 0, 1);
        chk("s5_next", out_sum, 24);
        step(0, 0, 0, 1);
        // overflow of a full-scale block
        for (int i = 0; i < 8; i++) step(1, 32'h7FFFFFFF, 0, 1);
`ifdef DRUM_MAC_ACC_SAT_EN
        chk("s6_sum", out_sum, 32'h7FFFFFFF);
        chk("s6_ovf", out_ovf, 1);
        chk("s6_model", sum_m, 32'h7FFFFFFF);
`else
        chk("s6_sum", out_sum, 32'hFFFFFFF8);
        chk("s6_ovf", out_ovf, 0);
        chk("s6_model", sum_m, 32'hFFFFFFF8);
`endif
        step(0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(0, 40)) - 32'd20,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/drum_mac_acc.md
DRUM_MAC_ACC -- requirements
Module: drum_mac_acc

Interface
REQ-001 The block SHALL have parameter N, default 16: width of multiplicand a feeding the upstream DRUMk_M_N_s.
REQ-002 The block SHALL have parameter M, default 16: width of multiplier b feeding the upstream DRUMk_M_N_s.
REQ-003 The block SHALL have parameter LEN, default 8, legal range 2..256: number of products per accumulation block.
REQ-004 The block SHALL have parameter ACC_W, default 32, legal range N+M..N+M+8: accumulator and result width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_prod carries a valid product.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_prod this cycle.
REQ-009 The block SHALL have port in_prod, input, N+M bits: signed product r from DRUMk_M_N_s.
REQ-010 The block SHALL have port clr, input, 1 bit: synchronous abort of the partial block.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_sum holds a completed block sum.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_sum.
REQ-013 The block SHALL have port out_sum, output, ACC_W bits: signed block sum.
REQ-014 The block SHALL have port out_ovf, output, 1 bit: the block sum saturated.

Function
REQ-015 An input handshake SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; an output handshake SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-016 On each input handshake, acc SHALL be updated as acc + sign_extend(in_prod) to ACC_W bits, two's-complement; cnt SHALL increment.
REQ-017 The handshake at cnt=LEN-1 is the last of the block; on that edge, out_sum SHALL load acc+sext(in_prod), out_valid SHALL be set to 1, and acc and cnt SHALL both be set to 0.
REQ-018 Latency from the last input handshake to out_valid=1 SHALL be exactly one cycle.
REQ-019 The output register SHALL be a two-state FSM, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY to FULL on the last input handshake.
  - FULL to EMPTY on an output handshake with no simultaneous last input handshake.
  - FULL stays FULL, with out_sum reloaded, on an output handshake together with a last input handshake.
REQ-020 Accumulation SHALL continue while the FSM is FULL.
REQ-021 in_ready SHALL be 0 only when clr=0, FSM is FULL, out_ready=0 and cnt=LEN-1; otherwise in_ready SHALL be 1.
REQ-022 Sustained throughput SHALL be one product per cycle when out_ready is held at 1.
REQ-023 out_sum and out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 clr=1 SHALL zero acc and cnt, and SHALL discard any product presented in that same cycle; in_ready SHALL be 1 while clr=1.
REQ-025 clr SHALL NOT affect out_valid, out_sum or out_ovf.
REQ-026 Products SHALL be summed exactly as received; the block SHALL NOT apply any correction to the one's-complement sign handling of DRUMk_M_N_s.

Reset
REQ-027 While rst_n=0, asynchronously, the block SHALL hold acc=0, cnt=0, FSM=EMPTY, out_valid=0, out_sum=0 and out_ovf=0.
REQ-028 in_ready SHALL be 1 while rst_n=0.
REQ-029 A reset asserted mid-block SHALL discard all partial state.
REQ-030 The first input handshake after reset SHALL be the first product of a new block.

Configuration
REQ-031 With macro DRUM_MAC_ACC_SAT_EN defined, each addition SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) on signed overflow.
REQ-032 With DRUM_MAC_ACC_SAT_EN defined, a clamp anywhere in a block SHALL set an internal sticky flag; the flag SHALL load into out_ovf with out_sum and clear together with acc.
REQ-033 Without DRUM_MAC_ACC_SAT_EN, additions SHALL wrap modulo 2^ACC_W and out_ovf SHALL be tied to 0.

Verification
REQ-034 Bench SHALL cover: LEN=8, in_prod=1000 for 8 consecutive cycles, out_ready=1 -> out_valid=1 for one cycle, one cycle after the 8th product, with out_sum=8000 and in_ready constantly 1.
REQ-035 Bench SHALL cover: in_prod alternating +300/-500 over 8 products -> out_sum=-800 (sign-extended).
REQ-036 Bench SHALL cover: out_ready=0 during two consecutive blocks of 1s -> first out_sum=8 held stable, in_ready=0 at the second block's 8th product; on release of out_ready: out_sum=8 taken, then out_sum=8 for the second block.
REQ-037 Bench SHALL cover: clr after 3 products of value 5, then 8 products of 2 -> out_sum=16.
REQ-038 Bench SHALL cover: rst_n low mid-block after 4 products -> all outputs 0 immediately; the next block sums only post-reset products.
REQ-039 Bench SHALL cover: ACC_W=32 with DRUM_MAC_ACC_SAT_EN and 8 products of 0x7FFF_FFFF -> out_sum=0x7FFF_FFFF and out_ovf=1; without the macro -> wrapped value 0xFFFF_FFF8 and out_ovf=0.
